arbitro_mux4: RTL

- Round-robin arbiter/scheduler that shares one width-bit output channel between four requesters.
- Drives the select lines of an internal mux4a1 and registers the selected data onto F with a valid strobe.
- Sits in front of any consumer that expects one data stream fed from four sources A/B/C/D.
- Grant is held while the owner keeps requesting, bounded by MAX_HOLD cycles when other requesters are waiting.

---
 rtl/arbitro_mux4_pkg.sv | 21 ++
 rtl/arbitro_mux4_selector_rr.sv | 30 +++
 rtl/mux4a1.sv | 23 ++
 rtl/arbitro_mux4.sv | 119 +++++++++++
 4 files changed

// File: rtl/arbitro_mux4_pkg.sv
// Shared definitions for the arbitro_mux4 round-robin arbiter: FSM states,
// requester count and the one-hot to index helper.
package arbitro_mux4_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = idx | 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/arbitro_mux4_selector_rr.sv
// Combinational round-robin picker: first set request after 'last' (mod 4),
// optionally skipping the current owner so it cannot re-win its own release.
module selector_rr
   import arbitro_mux4_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last,
   input  logic [1:0]      mask_idx,
   input  logic            mask_en,
   output logic [1:0]      pick,
   output logic            found
);

   logic [1:0] cand;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = '0;
      // 2-bit addition wraps naturally, so k=NREQ revisits 'last' itself.
      for (int k = 1; k <= NREQ; k++) begin
         cand = last + 2'(k);
         if (!found && req[cand] && !(mask_en && (cand == mask_idx))) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4a1.sv
// Four-to-one data multiplexer; {s1,s0} = 00..11 selects A..D.
module mux4a1 #(
   parameter int width = 4
) (
   input  logic [width-1:0] A,
   input  logic [width-1:0] B,
   input  logic [width-1:0] C,
   input  logic [width-1:0] D,
   input  logic             s0,
   input  logic             s1,
   output logic [width-1:0] F
);

   always_comb begin
      case ({s1, s0})
         2'b00:   F = A;
         2'b01:   F = B;
         2'b10:   F = C;
         default: F = D;
      endcase
   end

endmodule

// File: rtl/arbitro_mux4.sv
// Round-robin scheduler sharing one output channel between four sources;
// grant is held while requested, bounded by MAX_HOLD under contention.
module arbitro_mux4
   import arbitro_mux4_pkg::*;
#(
   parameter int width    = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [width-1:0] A,
   input  logic [width-1:0] B,
   input  logic [width-1:0] C,
   input  logic [width-1:0] D,
   output logic [3:0]       gnt,
   output logic             s0,
   output logic             s1,
   output logic [width-1:0] F,
   output logic             valid
);

   localparam int             CW       = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);

   state_t           state, state_nxt;
   logic [3:0]       gnt_nxt;
   logic [1:0]       sel, sel_nxt;
   logic [1:0]       last, last_nxt;
   logic [CW-1:0]    count, count_nxt;
   logic [width-1:0] mux_out, f_nxt;
   logic             valid_nxt;
   logic [1:0]       idx, pick;
   logic             found, owner_req, take;

   assign s0  = sel[0];
   assign s1  = sel[1];
   assign idx = onehot_to_idx(gnt);

   mux4a1 #(.width(width)) u_mux (
      .A(A), .B(B), .C(C), .D(D),
      .s0(s0), .s1(s1),
      .F(mux_out)
   );

   selector_rr u_sel (
      .req(req),
      .last(last),
      .mask_idx(idx),
      .mask_en(state == ST_BUSY),
      .pick(pick),
      .found(found)
   );

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      sel_nxt   = sel;
      last_nxt  = last;
      count_nxt = count;
      f_nxt     = F;
      valid_nxt = 1'b0;
      take      = 1'b0;
      owner_req = req[idx];
      case (state)
         ST_IDLE: begin
            if (found) take = 1'b1;
         end
         ST_BUSY: begin
            if (owner_req) begin
               f_nxt     = mux_out;
               valid_nxt = 1'b1;
            end
            // Owner still transfers on a preempting edge; the handover follows.
            if (!owner_req) begin
               if (found) begin
                  take = 1'b1;
               end else begin
                  gnt_nxt   = '0;
                  state_nxt = ST_IDLE;
               end
            end else if ((count == HOLD_MAX) && found) begin
               take = 1'b1;
            end else if (count != HOLD_MAX) begin
               count_nxt = count + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (take) begin
         gnt_nxt   = 4'b0001 << pick;
         sel_nxt   = pick;
         last_nxt  = pick;
         count_nxt = CW'(1);
         state_nxt = ST_BUSY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         gnt   <= '0;
         sel   <= '0;
         last  <= 2'd3;
         count <= '0;
         F     <= '0;
         valid <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         sel   <= sel_nxt;
         last  <= last_nxt;
         count <= count_nxt;
         F     <= f_nxt;
         valid <= valid_nxt;
      end
   end

endmodule
